dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_rr_pick.sv | 13 +
 rtl/dmem_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared defaults, port id type and FSM encoding for the data-memory arbiter
package dmem_arbiter_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LOCK_MAX_DEF = 4;
  typedef logic port_id_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;
  function automatic state_t own_of(input port_id_t p);
    return p ? OWN1 : OWN0;
  endfunction
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way round-robin selector, the port not granted last wins a conflict
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last_gnt,
  output logic     gnt0,
  output logic     gnt1
);
  assign gnt0 = req0 & (~req1 | last_gnt);
  assign gnt1 = req1 & (~req0 | ~last_gnt);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter with round-robin, bounded lock ownership and load return routing
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  state_t           state, state_nx;
  port_id_t         last_gnt, rd_owner, sel;
  logic [CNT_W-1:0] beats, beats_nx, nb;
  logic             rd_pend, pick0, pick1, gnt0, gnt1, any_gnt;
  logic             sel_we, sel_lock, own_lock, at_max, keep;
  dmem_rr_pick u_pick (
    .req0    (p0_req),
    .req1    (p1_req),
    .last_gnt(last_gnt),
    .gnt0    (pick0),
    .gnt1    (pick1)
  );
  // An owner blocks the other port even while it idles
  assign gnt0     = ~reset & ((state == IDLE) ? pick0 : (state == OWN0) & p0_req);
  assign gnt1     = ~reset & ((state == IDLE) ? pick1 : (state == OWN1) & p1_req);
  assign any_gnt  = gnt0 | gnt1;
  assign sel      = gnt1;
  assign sel_we   = sel ? p1_we : p0_we;
  assign sel_lock = sel ? p1_lock : p0_lock;
  assign own_lock = (state == OWN1) ? p1_lock : p0_lock;
  assign nb       = (state == IDLE) ? CNT_W'(1) : (beats == CNT_W'(LOCK_MAX)) ? beats : beats + 1'b1;
  assign at_max   = nb >= CNT_W'(LOCK_MAX);
  assign keep     = sel_lock & ~at_max;
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      beats    <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      state    <= state_nx;
      beats    <= beats_nx;
      last_gnt <= any_gnt ? sel : last_gnt;
      rd_pend  <= any_gnt & ~sel_we;
      rd_owner <= any_gnt ? sel : rd_owner;
    end
  end
  // A grant at the lock limit is still served, then ownership is dropped
  always_comb begin
    state_nx = state;
    beats_nx = beats;
    if (any_gnt) begin
      state_nx = keep ? own_of(sel) : IDLE;
      beats_nx = keep ? nb : '0;
    end else if (state != IDLE && !own_lock) begin
      state_nx = IDLE;
      beats_nx = '0;
    end
  end
  always_comb begin
    p0_gnt    = gnt0;
    p1_gnt    = gnt1;
    mem_write = any_gnt & sel_we;
    mem_addr  = !any_gnt ? '0 : sel ? p1_addr : p0_addr;
    mem_wdata = !any_gnt ? '0 : sel ? p1_wdata : p0_wdata;
    p0_rvalid = ~reset & rd_pend & ~rd_owner;
    p1_rvalid = ~reset & rd_pend & rd_owner;
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
  end
endmodule
